// File: rtl/lsb_serializer.sv
// LSB-first parallel-to-serial feeder with valid/ready input, a one-word
// pending buffer for gapless back-to-back words, and word framing strobes.
module lsb_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] p_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             word_start,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] pend;
  logic [CW-1:0]    bitcnt;
  logic             pend_valid;
  logic             accept;
  logic             last_bit;

  assign accept   = in_valid && in_ready;
  assign last_bit = (bitcnt == CW'(WIDTH - 1));

  // Word sequencing: load, shift, and hand over to the pending or incoming word
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      shreg      <= {WIDTH{1'b0}};
      pend       <= {WIDTH{1'b0}};
      bitcnt     <= {CW{1'b0}};
      pend_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg  <= p_in;
            bitcnt <= {CW{1'b0}};
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (!last_bit) begin
            shreg  <= shreg >> 1;
            bitcnt <= bitcnt + CW'(1);
            if (accept) begin
              pend       <= p_in;
              pend_valid <= 1'b1;
            end
          end else if (pend_valid) begin
            // accept cannot coincide here: in_ready is low while pending is full
            shreg      <= pend;
            pend_valid <= 1'b0;
            bitcnt     <= {CW{1'b0}};
          end else if (accept) begin
            shreg  <= p_in;
            bitcnt <= {CW{1'b0}};
          end else begin
            bitcnt <= {CW{1'b0}};
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode straight from registered state
  always_comb begin
    in_ready   = !clr && !pend_valid;
    s_valid    = (state == SHIFT);
    s_out      = (state == SHIFT) && shreg[0];
    word_start = (state == SHIFT) && (bitcnt == {CW{1'b0}});
    word_done  = (state == SHIFT) && last_bit;
    busy       = (state == SHIFT) || pend_valid;
  end

endmodule

// File: tb/tb_lsb_serializer.sv
// Self-checking bench: directed and random words compared against a bit-queue
// reference model, plus a bench-side right-shifting deserializer.
module tb_lsb_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clr;
  logic [W-1:0] p_in;
  logic         in_valid;
  logic         in_ready, s_out, s_valid, word_start, word_done, busy;

  logic [7:0]   p8;
  logic         in_valid8;
  logic         in_ready8, s_out8, s_valid8, word_start8, word_done8, busy8;

  int errors = 0;
  int checks = 0;

  logic         bq[$];    // bits still to appear on s_out, front = current bit
  logic [W-1:0] wq[$];    // words in flight, front = word currently on the line
  logic [W-1:0] deser;
  logic         acc;

  always #5 clk = ~clk;

  lsb_serializer #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .p_in(p_in), .in_valid(in_valid), .in_ready(in_ready),
    .s_out(s_out), .s_valid(s_valid), .word_start(word_start),
    .word_done(word_done), .busy(busy)
  );

  lsb_serializer #(.WIDTH(8)) dut8 (
    .clk(clk), .clr(clr), .p_in(p8), .in_valid(in_valid8), .in_ready(in_ready8),
    .s_out(s_out8), .s_valid(s_valid8), .word_start(word_start8),
    .word_done(word_done8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after negedge, check outputs, advance model at posedge
  task automatic cycle(input logic v, input logic [W-1:0] d, output logic a);
    int n;
    logic sbit;
    logic [W-1:0] dw;
    @(negedge clk);
    in_valid = v;
    p_in     = d;
    #1;
    n = bq.size();
    chk("s_valid",    {31'd0, s_valid},    {31'd0, n > 0});
    chk("s_out",      {31'd0, s_out},      {31'd0, (n > 0) ? bq[0] : 1'b0});
    chk("word_start", {31'd0, word_start}, {31'd0, (n > 0) && (n % W == 0)});
    chk("word_done",  {31'd0, word_done},  {31'd0, (n % W == 1)});
    chk("busy",       {31'd0, busy},       {31'd0, n > 0});
    chk("in_ready",   {31'd0, in_ready},   {31'd0, n <= W});
    sbit = s_out;
    a = v && (n <= W);
    @(posedge clk);
    deser = {sbit, deser[W-1:1]};
    if (n > 0) begin
      void'(bq.pop_front());
      if (n % W == 1) begin
        dw = wq.pop_front();
        chk("deser_word", {28'd0, deser}, {28'd0, dw});
      end
    end
    if (a) begin
      for (int i = 0; i < W; i++) bq.push_back(d[i]);
      wq.push_back(d);
    end
  endtask

  task automatic send(input logic [W-1:0] d);
    logic a;
    int guard;
    a = 1'b0;
    guard = 0;
    while (!a && guard < 3 * W) begin
      cycle(1'b1, d, a);
      guard++;
    end
    chk("send_accept_timeout", {31'd0, a}, 32'd1);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, {W{1'b0}}, a);
  endtask

  initial begin
    logic [7:0] pat8;
    clr = 1'b1; in_valid = 1'b0; p_in = {W{1'b0}}; in_valid8 = 1'b0; p8 = 8'h00;
    deser = {W{1'b0}};
    #12;
    chk("rst_s_out", {31'd0, s_out}, 32'd0);
    chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_word_start", {31'd0, word_start}, 32'd0);
    chk("rst_word_done", {31'd0, word_done}, 32'd0);
    @(negedge clk);
    clr = 1'b0;

    // single word 1011, then idle
    send(4'b1011);
    idle(6);

    // back-to-back with in_valid held high
    send(4'hA);
    send(4'h5);
    send(4'h3);
    idle(14);

    // new word presented exactly on the last-bit edge with pending empty
    send(4'hF);
    idle(3);
    cycle(1'b1, 4'hC, acc);
    chk("lastbit_accept", {31'd0, acc}, 32'd1);
    idle(6);

    // async reset mid-word with a pending word
    send(4'h9);
    idle(1);
    send(4'h6);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    clr = 1'b1;
    #1;
    chk("clr_s_out", {31'd0, s_out}, 32'd0);
    chk("clr_s_valid", {31'd0, s_valid}, 32'd0);
    chk("clr_busy", {31'd0, busy}, 32'd0);
    chk("clr_in_ready", {31'd0, in_ready}, 32'd0);
    chk("clr_word_start", {31'd0, word_start}, 32'd0);
    chk("clr_word_done", {31'd0, word_done}, 32'd0);
    bq.delete();
    wq.delete();
    @(negedge clk);
    clr = 1'b0;
    send(4'h2);
    idle(6);

    // random traffic
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] rd;
      rd = W'($urandom);
      cycle(1'(($urandom_range(0, 3) != 0)), rd, acc);
    end
    idle(12);

    // WIDTH=8 instance: single word 81
    pat8 = 8'h81;
    @(negedge clk);
    in_valid8 = 1'b1;
    p8 = pat8;
    #1;
    chk("w8_ready", {31'd0, in_ready8}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid8 = 1'b0;
      #1;
      chk("w8_s_out", {31'd0, s_out8}, {31'd0, pat8[i]});
      chk("w8_s_valid", {31'd0, s_valid8}, 32'd1);
      chk("w8_word_start", {31'd0, word_start8}, {31'd0, i == 0});
      chk("w8_word_done", {31'd0, word_done8}, {31'd0, i == 7});
    end
    @(negedge clk);
    #1;
    chk("w8_idle_valid", {31'd0, s_valid8}, 32'd0);
    chk("w8_idle_busy", {31'd0, busy8}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
